// File: rtl/piso_frame_pkg.sv
// Shared types and helpers for the framed parallel-in/serial-out transmitter.
// Frame layout: start bit, DATA_W data bits MSB first, optional parity, stop bit.
package piso_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Line level between frames and during the stop bit.
  localparam logic IDLE_LEVEL = 1'b1;

  // Number of serial bit slots in one frame.
  function automatic int frame_bits(input int data_w, input int parity_en);
    return 2 + data_w + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/piso_frame_serializer_bit_rate_divider.sv
// Bit-rate tick generator: one tick every DIV cycles, phase realigned by restart.
// The tick lands one cycle before the last cycle of each bit so the caller can register it.
module bit_rate_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV - 1);
  // Loading 1 on restart puts the first tick DIV-2 cycles after the restart edge.
  localparam logic [CNT_W-1:0] RELOAD = (DIV > 1) ? CNT_W'(1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/piso_frame_serializer.sv
// Framed PISO transmitter: accepts words over valid/ready and shifts them out MSB first
// as start / data / optional parity / stop, every output registered.
module piso_frame_serializer
  import piso_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              serial_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = $clog2(DATA_W) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                parity_q, parity_d;
  logic                bit_last_q, bit_last_d;
  logic                serial_out_q, serial_out_d;
  logic                s_ready_q, s_ready_d;
  logic                bit_strobe_q, bit_strobe_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                accept;
  logic                tick;

  assign accept = s_valid && s_ready_q;

  bit_rate_divider #(
    .DIV(CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (tick)
  );

  // Next-state and next-output logic; registered outputs are computed from state_d
  // so that each flag lines up with the serial bit it describes.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    parity_d     = parity_q;
    serial_out_d = serial_out_q;

    unique case (state_q)
      ST_IDLE: begin
        serial_out_d = IDLE_LEVEL;
      end
      ST_START: begin
        if (bit_last_q) begin
          state_d      = ST_DATA;
          serial_out_d = shift_q[DATA_W-1];
          shift_d      = shift_q << 1;
          idx_d        = '0;
        end
      end
      ST_DATA: begin
        if (bit_last_q) begin
          if (idx_q == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_d      = ST_PARITY;
              serial_out_d = parity_q;
            end else begin
              state_d      = ST_STOP;
              serial_out_d = IDLE_LEVEL;
            end
          end else begin
            serial_out_d = shift_q[DATA_W-1];
            shift_d      = shift_q << 1;
            idx_d        = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_last_q) begin
          state_d      = ST_STOP;
          serial_out_d = IDLE_LEVEL;
        end
      end
      ST_STOP: begin
        if (bit_last_q) begin
          state_d      = ST_IDLE;
          serial_out_d = IDLE_LEVEL;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        serial_out_d = IDLE_LEVEL;
      end
    endcase

    // Accept is only possible in IDLE or the last STOP cycle, so it overrides both.
    if (accept) begin
      state_d      = ST_START;
      shift_d      = s_data;
      parity_d     = (^s_data) ^ (PARITY_ODD != 0);
      serial_out_d = ~IDLE_LEVEL;
    end

    // A fresh accept realigns the divider, whose tick is stale in that cycle.
    bit_last_d   = tick && !(accept && (CLK_DIV > 1));
    bit_strobe_d = accept || (bit_last_q && (state_q != ST_IDLE) && (state_d != ST_IDLE));
    frame_done_d = (state_d == ST_STOP) && bit_last_d;
    s_ready_d    = (state_d == ST_IDLE) || frame_done_d;
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      parity_q     <= 1'b0;
      bit_last_q   <= 1'b0;
      serial_out_q <= IDLE_LEVEL;
      s_ready_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      parity_q     <= parity_d;
      bit_last_q   <= bit_last_d;
      serial_out_q <= serial_out_d;
      s_ready_q    <= s_ready_d;
      bit_strobe_q <= bit_strobe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign serial_out = serial_out_q;
  assign bit_strobe = bit_strobe_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench for piso_frame_serializer: four configurations checked every cycle
// against a per-cycle scoreboard filled at each accepted word.
module tb_piso_frame_serializer;
  import piso_frame_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic ser;
    logic stb;
    logic done;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] s_data  [N];
  logic       s_valid [N];
  logic       s_ready_w    [N];
  logic       serial_out_w [N];
  logic       bit_strobe_w [N];
  logic       busy_w       [N];
  logic       frame_done_w [N];

  exp_t        exp_q [N][$];
  bit          acc_v     [N];
  bit          cur_ready [N];
  int          since     [N];
  int          done_at   [N];
  logic [63:0] cap       [N];
  int          n_cmp;
  int          n_bad;
  int          acc_t [2];
  int          n_acc;
  int          tcount;

  function automatic int div_of(input int k);
    return (k == 3) ? 4 : 1;
  endfunction
  function automatic int pen_of(input int k);
    return (k == 2) ? 0 : 1;
  endfunction
  function automatic int odd_of(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  piso_frame_serializer #(.DATA_W(8), .CLK_DIV(1), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready_w[0]),
    .serial_out(serial_out_w[0]), .bit_strobe(bit_strobe_w[0]), .busy(busy_w[0]),
    .frame_done(frame_done_w[0]));
  piso_frame_serializer #(.DATA_W(8), .CLK_DIV(1), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready_w[1]),
    .serial_out(serial_out_w[1]), .bit_strobe(bit_strobe_w[1]), .busy(busy_w[1]),
    .frame_done(frame_done_w[1]));
  piso_frame_serializer #(.DATA_W(8), .CLK_DIV(1), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
    .clk(clk), .rst(rst), .s_data(s_data[2]), .s_valid(s_valid[2]), .s_ready(s_ready_w[2]),
    .serial_out(serial_out_w[2]), .bit_strobe(bit_strobe_w[2]), .busy(busy_w[2]),
    .frame_done(frame_done_w[2]));
  piso_frame_serializer #(.DATA_W(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u3 (
    .clk(clk), .rst(rst), .s_data(s_data[3]), .s_valid(s_valid[3]), .s_ready(s_ready_w[3]),
    .serial_out(serial_out_w[3]), .bit_strobe(bit_strobe_w[3]), .busy(busy_w[3]),
    .frame_done(frame_done_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, expv);
    end
  endtask

  // Expected per-cycle line contents for one frame, built from the bit layout.
  task automatic push_frame(input int k, input logic [7:0] d);
    int   nb;
    int   dv;
    logic b;
    exp_t e;
    nb = frame_bits(8, pen_of(k));
    dv = div_of(k);
    for (int j = 0; j < nb; j++) begin
      if (j == 0)                           b = 1'b0;
      else if (j <= 8)                      b = d[8-j];
      else if (j == 9 && pen_of(k) == 1)    b = (^d) ^ (odd_of(k) != 0);
      else                                  b = 1'b1;
      for (int c = 0; c < dv; c++) begin
        e.ser  = b;
        e.stb  = (c == 0);
        e.done = (j == nb - 1) && (c == dv - 1);
        exp_q[k].push_back(e);
      end
    end
  endtask

  task automatic check_reset(input int k);
    chk("rst_serial_out", k, serial_out_w[k], 1);
    chk("rst_s_ready",    k, s_ready_w[k],    0);
    chk("rst_busy",       k, busy_w[k],       0);
    chk("rst_bit_strobe", k, bit_strobe_w[k], 0);
    chk("rst_frame_done", k, frame_done_w[k], 0);
  endtask

  // One clock cycle: decide accepts from the model, clock, then compare all DUTs.
  task automatic cycle();
    exp_t e;
    logic busy_e;
    logic rdy_e;
    for (int k = 0; k < N; k++) begin
      acc_v[k] = s_valid[k] && cur_ready[k];
      if (acc_v[k]) push_frame(k, s_data[k]);
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (acc_v[k]) begin
        since[k]   = 1;
        cap[k]     = '0;
        done_at[k] = 0;
      end else begin
        since[k]++;
      end
      cap[k] = {cap[k][62:0], serial_out_w[k]};
      if (frame_done_w[k] === 1'b1) done_at[k] = since[k];
      if (exp_q[k].size() > 0) begin
        e      = exp_q[k].pop_front();
        busy_e = 1'b1;
        rdy_e  = (exp_q[k].size() == 0);
      end else begin
        e      = '{ser: 1'b1, stb: 1'b0, done: 1'b0};
        busy_e = 1'b0;
        rdy_e  = 1'b1;
      end
      chk("serial_out", k, serial_out_w[k], e.ser);
      chk("bit_strobe", k, bit_strobe_w[k], e.stb);
      chk("frame_done", k, frame_done_w[k], e.done);
      chk("busy",       k, busy_w[k],       busy_e);
      chk("s_ready",    k, s_ready_w[k],    rdy_e);
      cur_ready[k] = rdy_e;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input int k, input logic [7:0] d);
    int t;
    t = 0;
    s_data[k]  = d;
    s_valid[k] = 1'b1;
    do begin
      cycle();
      t++;
    end while (!acc_v[k] && t < 200);
    chk("accept_seen", k, acc_v[k], 1);
    s_valid[k] = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    for (int k = 0; k < N; k++) begin
      s_data[k]    = 8'h00;
      s_valid[k]   = 1'b0;
      cur_ready[k] = 1'b0;
      since[k]     = 0;
      done_at[k]   = 0;
      cap[k]       = '0;
    end

    // Reset values while rst is high, then release between edges.
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) check_reset(k);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) chk("rst_hold_s_ready", k, s_ready_w[k], 0);
    rst = 1'b0;
    run(2);

    // T1: defaults, 8'hA5
    send(0, 8'hA5);
    run(10);
    chk("t1_wave", 0, {21'd0, cap[0][10:0]}, {21'd0, 11'b01010010101});
    chk("t1_done_cycle", 0, done_at[0], 11);
    run(1);

    // T2: odd parity of 8'h01, and no-parity frame of 8'h80
    send(1, 8'h01);
    run(10);
    chk("t2_odd_wave", 1, {21'd0, cap[1][10:0]}, {21'd0, 11'b00000000101});
    send(2, 8'h80);
    run(9);
    chk("t2_nopar_wave", 2, {22'd0, cap[2][9:0]}, {22'd0, 10'b0100000001});
    chk("t2_nopar_done_cycle", 2, done_at[2], 10);
    run(2);

    // T3: CLK_DIV=4, 8'hF0
    send(3, 8'hF0);
    run(44);
    chk("t3_done_cycle", 3, done_at[3], 44);

    // T4: back-to-back 8'h12 then 8'h34 with s_valid held high
    s_data[0]  = 8'h12;
    s_valid[0] = 1'b1;
    n_acc      = 0;
    tcount     = 0;
    acc_t[0]   = 0;
    acc_t[1]   = 0;
    while (n_acc < 2 && tcount < 100) begin
      cycle();
      tcount++;
      if (acc_v[0]) begin
        acc_t[n_acc] = tcount;
        n_acc++;
        if (n_acc == 1) s_data[0] = 8'h34;
        else            s_valid[0] = 1'b0;
      end
    end
    chk("t4_accepts", 0, n_acc, 2);
    chk("t4_gap", 0, acc_t[1] - acc_t[0], 11);
    run(10);
    chk("t4_second_wave", 0, {21'd0, cap[0][10:0]}, {21'd0, 11'b00011010011});
    run(2);

    // T5: reset during data bit 3, then a clean frame
    send(0, 8'hC3);
    run(4);
    rst = 1'b1;
    #1;
    check_reset(0);
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      cur_ready[k] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_serial_out", 0, serial_out_w[0], 1);
    chk("t5_rst_s_ready",    0, s_ready_w[0],    0);
    chk("t5_rst_frame_done", 0, frame_done_w[0], 0);
    rst = 1'b0;
    run(1);
    send(0, 8'h5A);
    run(12);

    // T6: s_valid toggled and s_data scrambled while the frame is in flight
    send(0, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      cycle();
      s_valid[0] = (i % 2 == 0);
      s_data[0]  = 8'($urandom);
    end
    s_valid[0] = 1'b0;
    run(2);
    chk("t6_wave", 0, {21'd0, cap[0][10:0]}, {21'd0, 11'b00011110001});
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
